// File: rtl/uart_tx_buf.sv
// uart_tx_buf: 8N1 serial transmitter with a one-entry holding buffer.
// Sits downstream of the UART receiver to forward/loop back received bytes.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_buf #(
    parameter logic [12:0] BAUD_CNT_MAX = 13'd5207,
    parameter logic [3:0]  DATA_BITS    = 4'd8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       busy,
    output logic       ovf_flag
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 4'd1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  hold_data, hold_data_nxt;
    logic        hold_vld, hold_vld_nxt;
    logic        tx_nxt, busy_nxt, ovf_nxt;
    logic        bit_end;
    logic        load;
    logic [7:0]  load_data;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_nxt;
`endif

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            hold_data <= '0;
            hold_vld  <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            ovf_flag  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            hold_data <= hold_data_nxt;
            hold_vld  <= hold_vld_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            ovf_flag  <= ovf_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_nxt;
`endif
        end
    end

    // Next-state, bit timing, holding buffer and registered-output values
    always_comb begin
        state_nxt     = state;
        baud_nxt      = baud_cnt;
        bit_nxt       = bit_idx;
        shift_nxt     = shift_reg;
        hold_data_nxt = hold_data;
        hold_vld_nxt  = hold_vld;
        ovf_nxt       = 1'b0;
        load          = 1'b0;
        load_data     = pi_data;
        tx_nxt        = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_nxt       = par_bit;
`endif
        bit_end = (baud_cnt == BAUD_CNT_MAX);

        if (state != IDLE) begin
            baud_nxt = bit_end ? 13'd0 : baud_cnt + 13'd1;
        end

        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (pi_flag) begin
                    load      = 1'b1;
                    load_data = pi_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                        bit_nxt = '0;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (hold_vld) begin
                        // Held byte goes next; a coincident strobe refills the buffer
                        load      = 1'b1;
                        load_data = hold_data;
                        if (pi_flag) begin
                            hold_data_nxt = pi_data;
                        end else begin
                            hold_vld_nxt = 1'b0;
                        end
                    end else if (pi_flag) begin
                        load      = 1'b1;
                        load_data = pi_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobe during an active frame (not consumed at end of STOP): buffer or drop
        if (pi_flag && (state != IDLE) && !((state == STOP) && bit_end)) begin
            if (!hold_vld) begin
                hold_data_nxt = pi_data;
                hold_vld_nxt  = 1'b1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        if (load) begin
            state_nxt = START;
            shift_nxt = load_data;
            bit_nxt   = '0;
            baud_nxt  = '0;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^load_data;
`endif
        end

        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != IDLE) | hold_vld_nxt;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf with 16 clocks per bit.
// A monitor decodes every frame on tx and compares it against queued bytes.
module tb_uart_tx_buf;

    localparam int unsigned BIT_CLKS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CLKS = BIT_CLKS * FRAME_BITS;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       tx;
    logic       busy;
    logic       ovf_flag;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_buf #(
        .BAUD_CNT_MAX(13'd15),
        .DATA_BITS   (4'd8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pi_data (pi_data),
        .pi_flag (pi_flag),
        .tx      (tx),
        .busy    (busy),
        .ovf_flag(ovf_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle counter and overflow pulse counter
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (ovf_flag === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Present one byte for exactly one clock, starting at the current negedge
    task automatic send(input logic [7:0] d);
        pi_data = d;
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        pi_data = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 4 * FRAME_CLKS) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 32'(busy), 0);
        wait_n(4);
    endtask

    // Frame monitor: every bit must hold for BIT_CLKS clocks; decoded byte vs scoreboard
    initial begin : monitor
        logic [FRAME_BITS-1:0] bits;
        logic                  stable;
        logic                  aborted;
        logic                  cur;
        logic [7:0]            exp_b;
        cur = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && tx === 1'b0) begin
                start_q.push_back(cyc);
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < int'(FRAME_BITS); b++) begin
                    for (int c = 0; c < int'(BIT_CLKS); c++) begin
                        if (!(b == 0 && c == 0)) @(negedge sys_clk);
                        if (sys_rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) cur = tx;
                        else if (tx !== cur) stable = 1'b0;
                    end
                    if (aborted) break;
                    bits[b] = cur;
                end
                if (!aborted) begin
                    check("sb_frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("frame_data", 32'(bits[8:1]), 32'(exp_b));
                        check("start_bit", 32'(bits[0]), 0);
                        check("stop_bit", 32'(bits[FRAME_BITS-1]), 1);
                        check("bit_width", 32'(stable), 1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(bits[9]), 32'(^exp_b));
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s0;
        // Reset state
        wait_n(3);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf_flag), 0);
        sys_rst = 1'b0;
        wait_n(2);
        check("idle_tx", 32'(tx), 1);
        check("idle_busy", 32'(busy), 0);

        // T1: single byte 0x55, latency and busy length
        exp_q.push_back(8'h55);
        send(8'h55);
        check("t1_latency_tx", 32'(tx), 0);
        check("t1_busy_high", 32'(busy), 1);
        wait_n(FRAME_CLKS - 1);
        check("t1_busy_last", 32'(busy), 1);
        check("t1_stop_tx", 32'(tx), 1);
        wait_n(1);
        check("t1_busy_drop", 32'(busy), 0);
        wait_idle("t1_idle");

        // T2: back-to-back A3, 0F five cycles apart, no gap
        s0 = ovf_cnt;
        start_q.delete();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send(8'hA3);
        wait_n(4);
        send(8'h0F);
        wait_idle("t2_idle");
        check("t2_no_ovf", 32'(ovf_cnt - s0), 0);
        check("t2_frames", 32'(start_q.size()), 2);
        if (start_q.size() == 2) check("t2_gap", 32'(start_q[1] - start_q[0]), FRAME_CLKS);

        // T3: three strobes in one frame, third dropped with one-cycle ovf pulse
        s0 = ovf_cnt;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        send(8'h01);
        wait_n(2);
        send(8'h02);
        wait_n(2);
        send(8'h03);
        check("t3_ovf_pulse", 32'(ovf_flag), 1);
        wait_n(1);
        check("t3_ovf_clear", 32'(ovf_flag), 0);
        wait_idle("t3_idle");
        check("t3_ovf_count", 32'(ovf_cnt - s0), 1);

        // T4: strobe on the last STOP cycle while the buffer is full
        s0 = ovf_cnt;
        start_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC6);
        send(8'h3C);
        wait_n(4);
        send(8'h5A);
        wait_n(FRAME_CLKS - 6);
        send(8'hC6);
        wait_idle("t4_idle");
        check("t4_no_ovf", 32'(ovf_cnt - s0), 0);
        check("t4_frames", 32'(start_q.size()), 3);
        if (start_q.size() == 3) begin
            check("t4_gap1", 32'(start_q[1] - start_q[0]), FRAME_CLKS);
            check("t4_gap2", 32'(start_q[2] - start_q[1]), FRAME_CLKS);
        end

        // T5: reset mid-DATA of 0xFF with a byte held; clean 0x81 afterwards
        send(8'hFF);
        wait_n(3);
        send(8'h11);
        wait_n(40);
        sys_rst = 1'b1;
        #1;
        check("t5_rst_tx", 32'(tx), 1);
        check("t5_rst_busy", 32'(busy), 0);
        wait_n(2);
        sys_rst = 1'b0;
        wait_n(3);
        check("t5_no_resume_tx", 32'(tx), 1);
        check("t5_no_resume_busy", 32'(busy), 0);
        start_q.delete();
        exp_q.push_back(8'h81);
        send(8'h81);
        check("t5_launch_tx", 32'(tx), 0);
        wait_idle("t5_idle");
        check("t5_frames", 32'(start_q.size()), 1);

`ifdef UART_TX_PARITY_EN
        // T6: parity bytes 0x07 (parity 1) and 0x03 (parity 0)
        exp_q.push_back(8'h07);
        send(8'h07);
        wait_idle("t6a_idle");
        exp_q.push_back(8'h03);
        send(8'h03);
        wait_idle("t6b_idle");
`endif

        wait_n(5);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
